// File: rtl/sprite_pkg.sv
// Shared sprite geometry, palette index type and ROM sizing helpers.
package sprite_pkg;

  localparam int unsigned SPR_W      = 32;
  localparam int unsigned SPR_H      = 32;
  localparam int unsigned NUM_FRAMES = 4;
  localparam int unsigned FRAME_DIV  = 8;
  localparam int unsigned ROM_DEPTH  = SPR_W * SPR_H * NUM_FRAMES;

  typedef logic [3:0] pal_idx_t;

  localparam pal_idx_t TRANSPARENT_IDX = 4'h0;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Default fill when no image file is supplied: opaque, and frame-dependent
  // so each animation frame reads back distinguishably.
  function automatic pal_idx_t rom_fill(input int unsigned a);
    logic [31:0] av;
    av = 32'(a);
    return (av[3:0] ^ {av[11:10], 2'b00}) | 4'h1;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Sprite pixel ROM: 4-bit palette indices, one-cycle synchronous read.
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int unsigned AW = addr_width(ROM_DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [3:0]    q
);

  // Registered read of the fixed fill pattern.
  always_ff @(posedge clk) begin
    q <= rom_fill(32'(addr));
  end

endmodule

// File: rtl/sprite_index_fetch.sv
// Per-pixel sprite fetch: bounding-box test, mirrored/animated ROM address,
// palette index out two clocks after the scan position.
module sprite_index_fetch #(
  parameter int unsigned SPR_W      = sprite_pkg::SPR_W,
  parameter int unsigned SPR_H      = sprite_pkg::SPR_H,
  parameter int unsigned NUM_FRAMES = sprite_pkg::NUM_FRAMES,
  parameter int unsigned FRAME_DIV  = sprite_pkg::FRAME_DIV
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_tick,
  input  logic                          anim_en,
  input  logic                          flip_x,
  input  logic [9:0]                    sprite_x,
  input  logic [9:0]                    sprite_y,
  input  logic [9:0]                    draw_x,
  input  logic [9:0]                    draw_y,
  input  logic                          pix_valid,
  output logic [3:0]                    pal_index,
  output logic                          hit,
  output logic                          out_valid,
  output logic [$clog2(NUM_FRAMES)-1:0] anim_frame
);

  import sprite_pkg::*;

  localparam int unsigned FW    = $clog2(NUM_FRAMES);
  localparam int unsigned XW    = $clog2(SPR_W);
  localparam int unsigned YW    = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned DEPTH = SPR_W * SPR_H * NUM_FRAMES;
  localparam int unsigned AW    = addr_width(DEPTH);

  logic [9:0]      sx, sy;
  logic            sflip;
  logic [DIV_W-1:0] div;

  logic            inside_c;
  logic [XW-1:0]   rx_c, col_c;
  logic [YW-1:0]   ry_c;
  logic [AW-1:0]   addr_c;

  logic            inside_q, valid_q;
  pal_idx_t        rom_q;

  // Shadow position/flip: only visible after a frame_tick, so no mid-frame tearing.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx    <= '0;
      sy    <= '0;
      sflip <= 1'b0;
    end else if (frame_tick) begin
      sx    <= sprite_x;
      sy    <= sprite_y;
      sflip <= flip_x;
    end
  end

  // Animation: FRAME_DIV enabled ticks per frame step, frame wraps naturally.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div        <= '0;
      anim_frame <= '0;
    end else if (frame_tick && anim_en) begin
      if (div == DIV_W'(FRAME_DIV - 1)) begin
        div        <= '0;
        anim_frame <= anim_frame + FW'(1);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // Bounding box in 11 bits so a box straddling 1023 never wraps to column 0.
  always_comb begin
    inside_c = 1'b0;
    rx_c     = '0;
    ry_c     = '0;
    col_c    = '0;
    addr_c   = '0;
    inside_c = ({1'b0, draw_x} >= {1'b0, sx}) && ({1'b0, draw_x} < ({1'b0, sx} + 11'(SPR_W))) &&
               ({1'b0, draw_y} >= {1'b0, sy}) && ({1'b0, draw_y} < ({1'b0, sy} + 11'(SPR_H)));
    rx_c     = XW'(draw_x - sx);
    ry_c     = YW'(draw_y - sy);
    col_c    = sflip ? (XW'(SPR_W - 1) - rx_c) : rx_c;
    if (inside_c) begin
      addr_c = (AW'(anim_frame) * AW'(SPR_W * SPR_H)) + (AW'(ry_c) * AW'(SPR_W)) + AW'(col_c);
    end
  end

  // The ROM's read register is the stage-1 address register.
  sprite_rom #(
    .AW (AW)
  ) u_rom (
    .clk  (Clk),
    .addr (addr_c),
    .q    (rom_q)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      inside_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      inside_q <= inside_c && pix_valid;
      valid_q  <= pix_valid;
    end
  end

  // Stage 2: mask to transparent outside the sprite.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pal_index <= TRANSPARENT_IDX;
      hit       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      pal_index <= inside_q ? rom_q : TRANSPARENT_IDX;
      hit       <= inside_q && (rom_q != TRANSPARENT_IDX);
      out_valid <= valid_q;
    end
  end

endmodule

// File: tb/tb_sprite_index_fetch.sv
// Directed bench for sprite_index_fetch; ROM holds the default fill
// rom[a] = (a[3:0] ^ {a[11:10],2'b00}) | 1.
module tb_sprite_index_fetch;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick, anim_en, flip_x, pix_valid;
  logic [9:0] sprite_x, sprite_y, draw_x, draw_y;
  logic [3:0] pal_index;
  logic       hit, out_valid;
  logic [1:0] anim_frame;

  int total = 0;
  int bad   = 0;

  sprite_index_fetch dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .anim_en    (anim_en),
    .flip_x     (flip_x),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .pix_valid  (pix_valid),
    .pal_index  (pal_index),
    .hit        (hit),
    .out_valid  (out_valid),
    .anim_frame (anim_frame)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, then check the outputs two clocks later.
  task automatic px(input string tag, input logic [9:0] x, input logic [9:0] y, input logic v,
                    input logic [3:0] ep, input logic eh, input logic ev);
    @(negedge Clk);
    draw_x = x; draw_y = y; pix_valid = v;
    @(negedge Clk);
    @(negedge Clk);
    chk({tag, ".pal"}, 16'(pal_index), 16'(ep));
    chk({tag, ".hit"}, 16'(hit), 16'(eh));
    chk({tag, ".vld"}, 16'(out_valid), 16'(ev));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk); frame_tick = 1'b1;
      @(negedge Clk); frame_tick = 1'b0;
    end
  endtask

  logic [9:0] st_x [4] = '{10'd100, 10'd110, 10'd132, 10'd131};
  logic [9:0] st_y [4] = '{10'd50,  10'd50,  10'd50,  10'd81};
  logic [3:0] st_p [4] = '{4'h1,    4'hB,    4'h0,    4'hF};
  logic       st_h [4] = '{1'b1,    1'b1,    1'b0,    1'b1};

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0; anim_en = 1'b0; flip_x = 1'b0; pix_valid = 1'b0;
    sprite_x = '0; sprite_y = '0; draw_x = '0; draw_y = '0;
    repeat (3) @(negedge Clk);
    chk("rst.pal", 16'(pal_index), 16'h0);
    chk("rst.hit", 16'(hit), 16'h0);
    chk("rst.vld", 16'(out_valid), 16'h0);
    chk("rst.frame", 16'(anim_frame), 16'h0);
    Reset_n = 1'b1;

    // Basic hits and corners
    sprite_x = 10'd100; sprite_y = 10'd50;
    ticks(1);
    px("tl",  10'd100, 10'd50, 1'b1, 4'h1, 1'b1, 1'b1);
    px("br",  10'd131, 10'd81, 1'b1, 4'hF, 1'b1, 1'b1);
    px("mid", 10'd105, 10'd52, 1'b1, 4'h5, 1'b1, 1'b1);

    // Misses and invalid pixels
    px("mx_r", 10'd132, 10'd50, 1'b1, 4'h0, 1'b0, 1'b1);
    px("mx_l", 10'd99,  10'd50, 1'b1, 4'h0, 1'b0, 1'b1);
    px("my_b", 10'd100, 10'd82, 1'b1, 4'h0, 1'b0, 1'b1);
    px("inv",  10'd100, 10'd50, 1'b0, 4'h0, 1'b0, 1'b0);

    // Back-to-back pixels, one per clock
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (i >= 2) begin
        chk($sformatf("st%0d.pal", i - 2), 16'(pal_index), 16'(st_p[i-2]));
        chk($sformatf("st%0d.hit", i - 2), 16'(hit), 16'(st_h[i-2]));
      end
      if (i < 4) begin
        draw_x = st_x[i]; draw_y = st_y[i]; pix_valid = 1'b1;
      end else begin
        pix_valid = 1'b0;
      end
    end

    // Horizontal mirror
    flip_x = 1'b1;
    ticks(1);
    px("fl_l", 10'd100, 10'd50, 1'b1, 4'hF, 1'b1, 1'b1);
    px("fl_r", 10'd131, 10'd50, 1'b1, 4'h1, 1'b1, 1'b1);
    px("fl_2", 10'd102, 10'd50, 1'b1, 4'hD, 1'b1, 1'b1);
    flip_x = 1'b0;
    ticks(1);

    // Animation stepping and wrap
    anim_en = 1'b1;
    ticks(7);
    chk("an7", 16'(anim_frame), 16'h0);
    ticks(1);
    chk("an8", 16'(anim_frame), 16'h1);
    px("f1_0", 10'd100, 10'd50, 1'b1, 4'h5, 1'b1, 1'b1);
    px("f1_2", 10'd102, 10'd50, 1'b1, 4'h7, 1'b1, 1'b1);
    ticks(8);
    chk("an16", 16'(anim_frame), 16'h2);
    px("f2_0", 10'd100, 10'd50, 1'b1, 4'h9, 1'b1, 1'b1);
    ticks(8);
    chk("an24", 16'(anim_frame), 16'h3);
    px("f3_0", 10'd100, 10'd50, 1'b1, 4'hD, 1'b1, 1'b1);
    ticks(8);
    chk("an32", 16'(anim_frame), 16'h0);
    px("f0_0", 10'd100, 10'd50, 1'b1, 4'h1, 1'b1, 1'b1);
    ticks(4);
    anim_en = 1'b0;
    ticks(20);
    chk("hold", 16'(anim_frame), 16'h0);
    anim_en = 1'b1;
    ticks(4);
    chk("resume", 16'(anim_frame), 16'h1);
    ticks(24);
    chk("back0", 16'(anim_frame), 16'h0);
    anim_en = 1'b0;

    // Shadowed position
    sprite_x = 10'd200;
    px("sh_old", 10'd100, 10'd50, 1'b1, 4'h1, 1'b1, 1'b1);
    ticks(1);
    px("sh_miss", 10'd100, 10'd50, 1'b1, 4'h0, 1'b0, 1'b1);
    px("sh_new",  10'd200, 10'd50, 1'b1, 4'h1, 1'b1, 1'b1);
    sprite_x = 10'd1010;
    ticks(1);
    px("edge_in",  10'd1015, 10'd50, 1'b1, 4'h5, 1'b1, 1'b1);
    px("edge_end", 10'd1023, 10'd50, 1'b1, 4'hD, 1'b1, 1'b1);
    px("nowrap",   10'd5,    10'd50, 1'b1, 4'h0, 1'b0, 1'b1);

    // Reset mid-stream
    anim_en = 1'b1;
    ticks(8);
    anim_en = 1'b0;
    chk("pre_rst", 16'(anim_frame), 16'h1);
    @(negedge Clk);
    draw_x = 10'd1015; draw_y = 10'd50; pix_valid = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("mrst.pal", 16'(pal_index), 16'h0);
    chk("mrst.hit", 16'(hit), 16'h0);
    chk("mrst.vld", 16'(out_valid), 16'h0);
    chk("mrst.frame", 16'(anim_frame), 16'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    px("post_old", 10'd1015, 10'd50, 1'b1, 4'h0, 1'b0, 1'b1);
    px("post_org", 10'd0,    10'd0,  1'b1, 4'h1, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
